// File: rtl/gb_pkg.sv
// Shared definitions for the gb_processor ALU datapath: ALU op encoding,
// register codes, flag bit positions and opcode-class decode masks.
package gb_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_OR  = 3'd6,
    OP_CP  = 3'd7
  } alu_op_e;

  localparam logic [2:0] REG_B   = 3'd0;
  localparam logic [2:0] REG_C   = 3'd1;
  localparam logic [2:0] REG_D   = 3'd2;
  localparam logic [2:0] REG_E   = 3'd3;
  localparam logic [2:0] REG_H   = 3'd4;
  localparam logic [2:0] REG_L   = 3'd5;
  localparam logic [2:0] REG_IMM = 3'd6;
  localparam logic [2:0] REG_A   = 3'd7;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  // Opcode classes: (instruction & MASK) == MATCH
  localparam logic [7:0] LD_MASK     = 8'hC7;
  localparam logic [7:0] LD_MATCH    = 8'h06;
  localparam logic [7:0] ALU_R_MASK  = 8'hC0;
  localparam logic [7:0] ALU_R_MATCH = 8'h80;
  localparam logic [7:0] ALU_I_MASK  = 8'hC7;
  localparam logic [7:0] ALU_I_MATCH = 8'hC6;

  function automatic logic [7:0] pack_flags(input logic z, input logic n,
                                            input logic h, input logic c);
    return {z, n, h, c, 4'b0000};
  endfunction

endpackage

// File: rtl/gb_alu.sv
// Combinational 8-bit ALU: add/sub with carry, logic ops and compare,
// producing the result, the packed F value and an accumulator write enable.
module gb_alu
  import gb_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  alu_op_e    op,
  output logic [7:0] result,
  output logic [7:0] flags,
  output logic       write_a
);

  logic       cin;
  logic [8:0] full;
  logic [4:0] half;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    result  = 8'h00;
    flags   = 8'h00;
    full    = 9'd0;
    half    = 5'd0;
    write_a = (op != OP_CP);
    cin     = (op == OP_ADC || op == OP_SBC) ? carry_in : 1'b0;

    unique case (op)
      OP_ADD, OP_ADC: begin
        full   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        half   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
        result = full[7:0];
        flags  = pack_flags(result == 8'h00, 1'b0, half[4], full[8]);
      end
      OP_SUB, OP_SBC, OP_CP: begin
        // Bit 8 / bit 4 of the widened difference is the borrow out.
        full   = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        half   = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, cin};
        result = full[7:0];
        flags  = pack_flags(result == 8'h00, 1'b1, half[4], full[8]);
      end
      OP_AND: begin
        result = a & b;
        flags  = pack_flags(result == 8'h00, 1'b0, 1'b1, 1'b0);
      end
      OP_XOR: begin
        result = a ^ b;
        flags  = pack_flags(result == 8'h00, 1'b0, 1'b0, 1'b0);
      end
      OP_OR: begin
        result = a | b;
        flags  = pack_flags(result == 8'h00, 1'b0, 1'b0, 1'b0);
      end
      default: begin
        result = 8'h00;
        flags  = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/gb_processor.sv
// LR35902-style ALU datapath: instruction decode, register file, F register
// and a registered {A, F} probe, one instruction per valid clock.
module gb_processor
  import gb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  instruction,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic [15:0] probe
);

  // Indexed by register code; entry REG_IMM is never written.
  logic [7:0] rf [8];
  logic [7:0] f;

  logic       is_ld;
  logic       is_alu_r;
  logic       is_alu_i;
  logic [2:0] dst_code;
  logic [2:0] src_code;
  logic [7:0] operand;
  alu_op_e    alu_op;
  logic [7:0] alu_result;
  logic [7:0] alu_flags;
  logic       alu_write_a;

  assign dst_code = instruction[5:3];
  assign src_code = instruction[2:0];
  assign alu_op   = alu_op_e'(instruction[5:3]);

  assign is_ld    = valid && ((instruction & LD_MASK) == LD_MATCH) && (dst_code != REG_IMM);
  assign is_alu_r = valid && ((instruction & ALU_R_MASK) == ALU_R_MATCH);
  assign is_alu_i = valid && ((instruction & ALU_I_MASK) == ALU_I_MATCH);

  assign operand = (is_alu_i || src_code == REG_IMM) ? data : rf[src_code];

  gb_alu u_alu (
    .a        (rf[REG_A]),
    .b        (operand),
    .carry_in (f[FLAG_C]),
    .op       (alu_op),
    .result   (alu_result),
    .flags    (alu_flags),
    .write_a  (alu_write_a)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the register file is a handful of flops, not a RAM, so every
      // entry is reset; reads straight after reset must return 0.
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      f     <= 8'h00;
      probe <= 16'h0000;
    end else begin
      // NOTE: non-blocking updates so the probe samples pre-edge {A, F},
      // giving its one-cycle lag behind the register file.
      if (is_ld) rf[dst_code] <= data;
      if (is_alu_r || is_alu_i) begin
        if (alu_write_a) rf[REG_A] <= alu_result;
        f <= alu_flags;
      end
      probe <= {rf[REG_A], f};
    end
  end

endmodule

// File: tb/tb_gb_processor.sv
// Directed self-checking bench for gb_processor with hand-computed probe values.
module tb_gb_processor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  instruction = 8'h00;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic [15:0] probe;

  int checks = 0;
  int errors = 0;

  gb_processor dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .data        (data),
    .valid       (valid),
    .probe       (probe)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: probe=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one instruction for the next rising edge.
  task automatic issue(input logic [7:0] op, input logic [7:0] d);
    @(negedge clock);
    instruction = op;
    data        = d;
    valid       = 1'b1;
  endtask

  // Drop valid and wait until the probe reflects the last accepted instruction.
  task automatic settle();
    @(negedge clock);
    valid       = 1'b0;
    instruction = 8'h80;
    data        = 8'hFF;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    check("reset_probe", probe, 16'h0000);

    // Registers read zero after reset: 0 + 0 sets only Z.
    issue(8'h80, 8'h00);
    issue(8'h84, 8'h00);
    issue(8'h85, 8'h00);
    settle();
    check("reset_regs_zero", probe, 16'h0080);

    // Load and add with carry out; also checks the one-cycle probe lag.
    do_reset();
    issue(8'h3E, 8'h3A);
    issue(8'h06, 8'hC6);
    issue(8'h80, 8'h00);
    @(negedge clock);
    valid = 1'b0;
    check("add_probe_lag", probe, 16'h3A00);
    @(negedge clock);
    check("add_carry", probe, 16'h00B0);

    // Carry chain with garbage on invalid cycles: 00 + C6 + 1.
    @(negedge clock);
    instruction = 8'h3E; data = 8'h99; valid = 1'b0;
    @(negedge clock);
    instruction = 8'hAF; data = 8'h55;
    @(negedge clock);
    check("garbage_ignored", probe, 16'h00B0);
    issue(8'h88, 8'h00);
    settle();
    check("adc_carry_in", probe, 16'hC700);

    issue(8'h3E, 8'h3E);
    issue(8'hD6, 8'h3E);
    settle();
    check("sub_zero", probe, 16'h00C0);

    issue(8'h3E, 8'h3E);
    issue(8'hFE, 8'h40);
    settle();
    check("cp_borrow", probe, 16'h3E50);

    issue(8'hFE, 8'h3E);
    settle();
    check("cp_equal", probe, 16'h3EC0);

    issue(8'h3E, 8'h5A);
    issue(8'hE6, 8'h0F);
    settle();
    check("and_imm", probe, 16'h0A20);

    // SUB sets Cy, then SBC consumes it: F0 - 0F - 1 = E0 with half borrow.
    issue(8'h3E, 8'h10);
    issue(8'hD6, 8'h20);
    settle();
    check("sub_borrow", probe, 16'hF050);
    issue(8'hDE, 8'h0F);
    settle();
    check("sbc_carry_in", probe, 16'hE060);

    issue(8'hAF, 8'h00);
    settle();
    check("xor_self", probe, 16'h0080);

    issue(8'h3E, 8'h81);
    issue(8'hF6, 8'h42);
    settle();
    check("or_imm", probe, 16'hC300);

    // LD (6),d8 and opcodes outside the decoded classes change nothing.
    issue(8'h36, 8'h55);
    issue(8'h76, 8'h00);
    issue(8'h01, 8'h12);
    issue(8'h47, 8'h00);
    settle();
    check("nop_opcodes", probe, 16'hC300);

    issue(8'h0E, 8'h0F);
    issue(8'h3E, 8'h01);
    issue(8'h81, 8'h00);
    settle();
    check("add_half_carry", probe, 16'h1020);

    issue(8'h3E, 8'hFF);
    issue(8'h87, 8'h00);
    settle();
    check("add_a_a", probe, 16'hFE30);

    // Asynchronous reset mid-cycle, held across an edge with a valid instruction.
    @(posedge clock);
    #2;
    instruction = 8'h3E; data = 8'h77; valid = 1'b1;
    reset = 1'b0;
    #1;
    check("async_reset", probe, 16'h0000);
    @(negedge clock);
    @(negedge clock);
    valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("reset_discards", probe, 16'h0000);

    issue(8'h3E, 8'h12);
    settle();
    check("first_after_reset", probe, 16'h1200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gb_processor.md
# gb_processor

Game Boy (LR35902-style) 8-bit ALU datapath with its own register file, driven one instruction at a time by a testbench or host sequencer. Each valid instruction reads operands from internal registers or an immediate data byte, executes, and updates the accumulator, the general registers and the flag register. The architectural state {A, F} is exposed on a probe port for scoreboard comparison.

## Interface
- No parameters. Data path fixed at 8 bits.
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- instruction  input  8  opcode, sampled when valid=1.
- data  input  8  immediate operand for immediate and load opcodes.
- valid  input  1  instruction qualifier; one instruction is executed per clock with valid=1.
- probe  output  16  registered {A[7:0], F[7:0]}.

## Operation
- State:
  - registers A, B, C, D, E, H, L (8 bits each);
  - F = {Z, N, Hc, Cy, 4'b0000}; F[3:0] always reads 0.
- Register code r[2:0]: 0=B, 1=C, 2=D, 3=E, 4=H, 5=L, 6=data input (immediate), 7=A.
- LD r,d8 (opcode 00rrr110):
  - rrr is the destination, loaded from data; flags unchanged.
  - rrr=6 is a no-op.
- ALU register ops (opcode 10ooo sss): source from the r table, operation ooo:
  - 0 = ADD;
  - 1 = ADC;
  - 2 = SUB;
  - 3 = SBC;
  - 4 = AND;
  - 5 = XOR;
  - 6 = OR;
  - 7 = CP.
- ALU immediate ops (opcode 11ooo110: C6, CE, D6, DE, E6, EE, F6, FE): same operations, source = data.
- Flag rules (Z = 8-bit result == 0 for all ALU ops):
  - ADD/ADC: N=0; Hc = carry out of bit 3; Cy = carry out of bit 7; ADC adds the old Cy.
  - SUB/SBC/CP: N=1; Hc = borrow from bit 4; Cy = borrow (A < operand + carry-in); SBC subtracts the old Cy.
  - CP updates F only; A is unchanged.
  - AND: N=0, Hc=1, Cy=0. XOR and OR: N=0, Hc=0, Cy=0.
- All arithmetic is modulo 256.
- Any other opcode with valid=1 is a NOP: no state change.
- valid=0: no state change; instruction and data are ignored.

## Timing
- reset low (asynchronous): all registers, F and probe go to 0x00 immediately; they stay at 0 while reset is low.
- An instruction accepted at rising edge k updates registers at edge k.
- probe shows the new {A, F} after edge k+1 (one registered output stage).
- Back-to-back instructions are supported every cycle; each one sees the results of the previous instruction (no hazards, no stalls).
- Reset asserted mid-stream discards any instruction being accepted at that edge.
- The first valid instruction after reset release is executed normally.

## Structure
- Package gb_pkg holds:
  - the op enum (ADD..CP);
  - the register-code localparams;
  - the flag bit positions (Z=7, N=6, H=5, C=4);
  - the opcode-class masks.
- Sub-module gb_alu: purely combinational. Inputs a, b, carry_in and op; outputs result, flags and a write-A enable. Its write-A enable is 0 for CP.
- Top level: decode, register file, F register and probe register.

## Test plan
- Reset: assert reset low for 3 cycles → probe = 0x0000; registers read 0 afterwards.
- Load and add with carry-out:
  - stimulus: LD A,0x3A (3E/3A); LD B,0xC6 (06/C6); ADD A,B (80);
  - response: probe 0x00B0 (Z=1, Hc=1, Cy=1).
- Subtract to zero: LD A,0x3E; SUB 0x3E (D6/3E) → probe 0x00C0.
- Compare with borrow: LD A,0x3E; CP 0x40 (FE/40) → probe 0x3E50 (A unchanged, N=1, Cy=1).
- Logical op: LD A,0x5A; AND 0x0F (E6/0F) → probe 0x0A20.
- Carry chain, invalid cycles, reset mid-stream:
  - stimulus: ADC after the carry-setting ADD, with valid=0 cycles carrying garbage opcodes interleaved;
  - response: garbage is ignored and the ADC includes Cy=1;
  - stimulus: reset pulsed mid-stream;
  - response: probe 0x0000 asynchronously.
